// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the non-pipelined MIPS-style core.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state.
module control_fsm #(
  parameter int FETCH_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        pc_reset,
  output logic        pc_lden,
  output logic        pc_sel,
  output logic        mux_rf_b_sel,
  output logic        alu_bin_sel,
  output logic [3:0]  alu_func,
  output logic        mem_wren,
  output logic        rf_wr_data_sel,
  output logic        rf_write,
  output logic        halted
);
  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
`ifdef CTRL_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;
  localparam logic [3:0] LAST = 4'(FETCH_WAIT - 1);
  state_t state;
  logic [3:0] cnt;
  logic [5:0] opc;
  logic r_type, addlike, andi, ori, imm, beq, bne, bj, br, lw, sw, legal;
  logic active, br_take, nop_ld;
  logic unused_bits;
  assign unused_bits = ^Instr[25:4];
  assign opc = Instr[31:26];
  assign r_type = opc == 6'b100000;
  assign addlike = opc == 6'b111000 || opc == 6'b111001 || opc == 6'b110000;
  assign andi = opc == 6'b110010;
  assign ori = opc == 6'b110011;
  assign imm = addlike || andi || ori;
  assign beq = opc == 6'b000000;
  assign bne = opc == 6'b000001;
  assign bj = opc == 6'b111111;
  assign br = beq || bne || bj;
  assign lw = opc == 6'b001111;
  assign sw = opc == 6'b011111;
  assign legal = r_type || imm || br || lw || sw;
  assign active = state == DECODE || state == EXEC || state == MEM || state == WB;
  assign br_take = beq ? Zero : bne ? !Zero : 1'b1;
  always_comb begin
    alu_func = !active ? 4'b0000 : r_type ? Instr[3:0] : andi ? 4'b0010 : ori ? 4'b0011 : br ? 4'b0001 : 4'b0000;
    alu_bin_sel = active && (imm || lw || sw);
    mux_rf_b_sel = active && (br || sw);
    rf_wr_data_sel = active && lw;
    pc_sel = state == EXEC && br && br_take;
  end
  // Enables are gated by Reset so an aborted instruction never commits.
  assign pc_reset = Reset;
  assign pc_lden = !Reset && (state == WB || (state == MEM && sw) || (state == EXEC && br) || nop_ld);
  assign mem_wren = !Reset && state == MEM && sw;
  assign rf_write = !Reset && state == WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = HALT;
  assign nop_ld = 1'b0;
`else
  localparam state_t ILL_NEXT = FETCH;
  assign nop_ld = state == DECODE && !legal;
  assign halted = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FETCH;
      cnt <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      halted <= 1'b0;
`endif
    end else begin
      cnt <= (state == FETCH && cnt != LAST) ? cnt + 4'd1 : '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      halted <= halted || (state == DECODE && !legal);
`endif
      case (state)
        FETCH: state <= cnt == LAST ? DECODE : FETCH;
        DECODE: state <= legal ? EXEC : ILL_NEXT;
        EXEC: state <= br ? FETCH : (lw || sw) ? MEM : WB;
        MEM: state <= sw ? FETCH : WB;
        WB: state <= FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
        HALT: state <= HALT;
`endif
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: checks two control_fsm instances (FETCH_WAIT 1 and 3) against a per-instruction timeline model.
module tb_control_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2];
  logic [31:0] instr[2];
  logic zero[2];
  logic [1:0][12:0] obs;
  int compared = 0;
  int mismatched = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pr, pl, ps, mb, bs, mw, wd, rw, hl;
    logic [3:0] fn;
    control_fsm #(.FETCH_WAIT(g == 0 ? 1 : 3)) dut (
      .Clk(clk), .Reset(rst[g]), .Instr(instr[g]), .Zero(zero[g]),
      .pc_reset(pr), .pc_lden(pl), .pc_sel(ps), .mux_rf_b_sel(mb),
      .alu_bin_sel(bs), .alu_func(fn), .mem_wren(mw), .rf_wr_data_sel(wd),
      .rf_write(rw), .halted(hl)
    );
    assign obs[g] = {pr, pl, ps, mb, bs, fn, mw, wd, rw, hl};
  end
  task automatic chk(string tag, logic [12:0] o, logic [12:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %b required %b", tag, o, e);
    end
  endtask
  // 0 = ALU, 1 = lw, 2 = sw, 3 = branch, 4 = illegal
  function automatic int cls(logic [5:0] op);
    case (op)
      6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011: return 0;
      6'b001111: return 1;
      6'b011111: return 2;
      6'b000000, 6'b000001, 6'b111111: return 3;
      default: return 4;
    endcase
  endfunction
  function automatic logic [3:0] efn(logic [31:0] i);
    case (i[31:26])
      6'b100000: return i[3:0];
      6'b110010: return 4'b0010;
      6'b110011: return 4'b0011;
      6'b000000, 6'b000001, 6'b111111: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction
  // Runs one instruction from FETCH cycle 1; rst_at pulses Reset in that cycle, zf<0 randomizes Zero.
  task automatic run(int k, logic [31:0] ins, int rst_at, int zf);
    int fw = k == 0 ? 1 : 3;
    int cl = cls(ins[31:26]);
    int len = (cl == 0 ? 4 : cl == 1 ? 5 : cl == 2 ? 4 : cl == 3 ? 3 : 2) + fw - 1;
    bit trap = 1'b0;
    logic [12:0] e;
    logic z, act, last, r, imm;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap = cl == 4;
`endif
    imm = cl == 0 && ins[31:26] != 6'b100000;
    instr[k] = ins;
    for (int c = 1; c <= len; c++) begin
      z = zf < 0 ? 1'($urandom) : zf[0];
      r = c == rst_at;
      zero[k] = z;
      rst[k] = r;
      act = c > fw;
      last = c == len;
      e = '0;
      e[12] = r;
      e[11] = last && !trap && !r;
      e[10] = last && cl == 3 && (ins[31:26] == 6'b000000 ? z : ins[31:26] == 6'b000001 ? !z : 1'b1);
      e[9] = act && (cl == 3 || cl == 2);
      e[8] = act && (imm || cl == 1 || cl == 2);
      e[7:4] = act ? efn(ins) : 4'b0000;
      e[3] = last && cl == 2 && !r;
      e[2] = act && cl == 1;
      e[1] = last && cl <= 1 && !r;
      #1;
      chk($sformatf("dut%0d op=%b cyc%0d", k, ins[31:26], c), obs[k], e);
      @(negedge clk);
      if (r) begin
        rst[k] = 1'b0;
        break;
      end
    end
  endtask
  logic [5:0] ops[14] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                          6'b000000, 6'b000001, 6'b111111, 6'b001111, 6'b011111,
                          6'b010101, 6'b000010, 6'b100001};
  initial begin
    logic [31:0] rnd;
    rst[0] = 1'b1; rst[1] = 1'b1;
    instr[0] = '0; instr[1] = '0;
    zero[0] = 1'b0; zero[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset dut0", obs[0], 13'h1000);
    chk("reset dut1", obs[1], 13'h1000);
    for (int k = 0; k < 2; k++) begin
      int fw = k == 0 ? 1 : 3;
      rst[k] = 1'b0;
      run(k, {6'b110000, 26'h0123456}, 0, -1);
      run(k, {6'b001111, 26'h0abcdef}, 0, -1);
      run(k, {6'b000000, 26'h0000010}, 0, 1);
      run(k, {6'b000001, 26'h0000010}, 0, 1);
      run(k, {6'b000001, 26'h0000010}, 0, 0);
      run(k, {6'b111111, 26'h0000010}, 0, 0);
      run(k, {6'b011111, 26'h1555555}, fw + 3, -1);
      run(k, {6'b100000, 26'h0000003}, 0, -1);
      run(k, {6'b001111, 26'h0000000}, fw + 4, -1);
      run(k, {6'b110010, 26'h0000000}, 0, -1);
      run(k, {6'b010101, 26'h2aaaaaa}, 0, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int c = 0; c < 20; c++) begin
        zero[k] = 1'($urandom);
        #1;
        chk($sformatf("dut%0d halt cyc%0d", k, c), obs[k], 13'h0001);
        @(negedge clk);
      end
      rst[k] = 1'b1;
      #1;
      chk($sformatf("dut%0d halt reset", k), obs[k], 13'h1001);
      @(negedge clk);
      rst[k] = 1'b0;
`endif
      for (int n = 0; n < 40; n++) begin
        rnd = $urandom;
        rnd[31:26] = ops[$urandom_range(0, 13)];
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (cls(rnd[31:26]) == 4) rnd[31:26] = 6'b100000;
`endif
        run(k, rnd, ($urandom_range(0, 9) == 0) ? $urandom_range(1, fw + 4) : 0, -1);
      end
      rst[k] = 1'b1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the non-pipelined MIPS-style core. It consumes `Instr` and `Zero` from the datapath and drives every datapath control input, one instruction at a time, through a fixed state sequence. It sits beside the datapath at the top level. Its outputs connect one-to-one to the datapath's control inputs.

## Interface

**Parameters**
- `FETCH_WAIT`, default 1: cycles spent in FETCH, matching the instruction-memory read latency. Legal range 1..15.

**Ports**
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Instr`  in  32  current instruction from the fetch unit.
- `Zero`  in  1  ALU zero flag, combinational from the datapath.
- `pc_reset`  out  1  PC reset; equals `Reset` combinationally.
- `pc_lden`  out  1  PC load enable.
- `pc_sel`  out  1  0 = PC+4, 1 = PC+4+(Immed<<2).
- `mux_rf_b_sel`  out  1  0 = `Instr[15:11]`, 1 = `Instr[20:16]` as RF read port B.
- `alu_bin_sel`  out  1  0 = RF_B, 1 = Immed.
- `alu_func`  out  4  ALU operation.
- `mem_wren`  out  1  data-memory write enable.
- `rf_wr_data_sel`  out  1  0 = ALU result, 1 = memory data.
- `rf_write`  out  1  register-file write enable.
- `halted`  out  1  sticky illegal-opcode flag.

## Operation

- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encode them in a 3-bit state register.
- **Opcode** = `Instr[31:26]`. The decoded classes are:
  - R-type `100000`: `alu_func = Instr[3:0]`.
  - ALU immediate: `li 111000`, `lui 111001`, `addi 110000` all use add (`0000`). `andi 110010` uses and (`0010`). `ori 110011` uses or (`0011`).
  - Branch: `beq 000000`, `bne 000001`, `b 111111`. All three use sub (`0001`), with `alu_bin_sel = 0` and `mux_rf_b_sel = 1`.
  - Memory: `lw 001111`, `sw 011111`. Both use add, with `alu_bin_sel = 1`. For `sw`, `mux_rf_b_sel = 1`.
  - Any other opcode is illegal.
- **Select outputs** (`alu_func`, `alu_bin_sel`, `mux_rf_b_sel`, `rf_wr_data_sel`) are combinational from `Instr` in every state except FETCH and HALT. In FETCH and HALT they are 0.
- **Enable outputs** (`pc_lden`, `mem_wren`, `rf_write`) are asserted only in the listed cycle, for exactly 1 cycle per instruction.
- **Per-class sequences:**
  - ALU (R-type and immediate): FETCH → DECODE → EXEC → WB. WB asserts `rf_write` and `pc_lden`, with `pc_sel = 0`.
  - `lw`: FETCH → DECODE → EXEC → MEM → WB. WB asserts `rf_write` and `pc_lden`, with `rf_wr_data_sel = 1`.
  - `sw`: FETCH → DECODE → EXEC → MEM. MEM asserts `mem_wren` and `pc_lden`.
  - Branch: FETCH → DECODE → EXEC. EXEC asserts `pc_lden`. `pc_sel` is `Zero` for `beq`, `~Zero` for `bne`, and 1 for `b`.
  - Illegal opcode: handled in DECODE; see Configuration.
- **FETCH counter:** a 4-bit counter is cleared on entry to FETCH. FETCH exits to DECODE when the count reaches `FETCH_WAIT-1`.
- `Instr` must be stable from DECODE until the PC load. The PC load is always the last cycle of an instruction, and the next state after it is FETCH.

## Timing

- **Reset values**, applied on the first rising edge with `Reset` high:
  - State = FETCH, counter = 0, `halted` = 0.
  - All enables and selects = 0, `alu_func` = `0000`.
  - `pc_reset` follows `Reset` with no delay.
- **Reset mid-instruction:** the instruction is aborted. No enable is asserted in any cycle where `Reset` is high, even if the state was MEM or WB.
- **Latency with `FETCH_WAIT` = 1:** ALU 4 cycles, `lw` 5, `sw` 4, branch 3. Add `FETCH_WAIT-1` cycles to each.
- **Branch decision:** `Zero` is sampled combinationally in EXEC, in the same cycle as `pc_lden`. There is no registered copy.
- **Simultaneous events:** `Reset` has priority over every transition, including HALT.

## Configuration

- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- **Defined:** an illegal opcode in DECODE moves to HALT. `halted` goes to 1 on that edge. In HALT, all enables are 0 and the FSM stays there until `Reset`.
- **Undefined:** an illegal opcode executes as a NOP. DECODE asserts `pc_lden` with `pc_sel = 0`, then returns to FETCH (2 + `FETCH_WAIT` − 1 cycles). `halted` is tied to 0 and there is no HALT state.

## Test plan

- `addi` (`110000`), `FETCH_WAIT` = 1 → `rf_write = 1` and `pc_lden = 1` only on cycle 4 after FETCH entry; `alu_bin_sel = 1`, `alu_func = 0000`.
- `lw` (`001111`) with `FETCH_WAIT` = 3 → `rf_write` with `rf_wr_data_sel = 1` on cycle 7; `mem_wren` stays 0 throughout.
- `beq` with `Zero = 1`, then `bne` with `Zero = 1` → `pc_lden` on cycle 3 for both; `pc_sel = 1` for `beq`, `pc_sel = 0` for `bne`.
- `sw` (`011111`) with `Reset` pulsed high during MEM → no `mem_wren` pulse; state = FETCH after the reset edge; `pc_reset = 1` during the pulse.
- Opcode `010101`:
  - With `CTRL_ILLEGAL_TRAP_EN` → `halted = 1` from the DECODE edge onward; enables stay 0 for 20 cycles; `Reset` clears `halted`.
  - Without the macro → `pc_lden` in DECODE, then FETCH.
- R-type `100000` with `Instr[3:0] = 0011` → `alu_func = 0011`, `mux_rf_b_sel = 0`, `alu_bin_sel = 0` during EXEC.
